// File: rtl/io_uart.sv
// io_uart: 8N1 UART on the cdp1802 I/O port bus.
// TX FIFO feeds the serialiser; RX fills a one-byte holding register.
//
// Ports:
//   clock, reset      single clock, synchronous active-high reset
//   io_n              port number from the core
//   io_inp, io_out    INP / OUT strobes (edge-detected)
//   io_dout           byte written by the core
//   io_din            byte returned to the core (combinational)
//   rxd, txd          serial in (async, idle high) / serial out
//   irq               rx_valid | tx_empty
module io_uart #(
  parameter int CLKDIV    = 16,
  parameter int TX_DEPTH  = 4,
  parameter int PORT_DATA = 1,
  parameter int PORT_STAT = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] io_n,
  input  logic       io_inp,
  input  logic       io_out,
  input  logic [7:0] io_dout,
  output logic [7:0] io_din,
  input  logic       rxd,
  output logic       txd,
  output logic       irq
);

  localparam int DW = $clog2(CLKDIV);
  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLKDIV - 1);
  localparam logic [DW-1:0] HALF_LAST = DW'(CLKDIV / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(TX_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // ---------------- strobes / decode ----------------
  logic out_q;
  logic inp_q;
  logic out_edge;
  logic inp_edge;
  logic sel_data;
  logic sel_stat;

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q <= 1'b0;
      inp_q <= 1'b0;
    end else begin
      out_q <= io_out;
      inp_q <= io_inp;
    end
  end

  assign out_edge = io_out & ~out_q;
  assign inp_edge = io_inp & ~inp_q;
  assign sel_data = (io_n == 3'(PORT_DATA));
  assign sel_stat = (io_n == 3'(PORT_STAT));

  // ---------------- TX FIFO ----------------
  logic [7:0]    mem [TX_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          tx_full;
  logic          tx_empty;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  assign tx_full = (count == FULL_CNT);
  assign push    = out_edge & sel_data & ~tx_full;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= io_dout;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  logic [1:0]    tx_state;
  logic [DW-1:0] tx_div;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh;
  logic          tx_last;

  assign tx_last  = (tx_div == DIV_LAST);
  assign tx_empty = (count == '0) && (tx_state == S_IDLE);

  // Popping at the end of STOP chains frames with no idle gap.
  assign pop = (count != '0) &&
               ((tx_state == S_IDLE) ||
                ((tx_state == S_STOP) && tx_last));

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_div   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      txd      <= 1'b1;
    end else begin
      // txd is registered from the state, one cycle behind it.
      case (tx_state)
        S_START: txd <= 1'b0;
        S_DATA:  txd <= tx_sh[0];
        default: txd <= 1'b1;
      endcase
      case (tx_state)
        S_IDLE: begin
          tx_div <= '0;
          if (pop) begin
            tx_sh    <= head;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_last) begin
            tx_div   <= '0;
            tx_bit   <= '0;
            tx_state <= S_DATA;
          end else begin
            tx_div <= tx_div + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_last) begin
            tx_div <= '0;
            tx_sh  <= {1'b0, tx_sh[7:1]};
            if (tx_bit == 3'd7) begin
              tx_state <= S_STOP;
            end else begin
              tx_bit <= tx_bit + 1'b1;
            end
          end else begin
            tx_div <= tx_div + 1'b1;
          end
        end
        default: begin
          if (tx_last) begin
            tx_div <= '0;
            if (pop) begin
              tx_sh    <= head;
              tx_state <= S_START;
            end else begin
              tx_state <= S_IDLE;
            end
          end else begin
            tx_div <= tx_div + 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- RX path ----------------
  logic          rx_s1;
  logic          rxs;
  logic [1:0]    rx_state;
  logic [DW-1:0] rx_div;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_armed;
  logic          rx_last;
  logic          rx_ok;
  logic          rx_bad;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          overrun;
  logic          frame_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rxs   <= rx_s1;
    end
  end

  assign rx_last = (rx_div == DIV_LAST);
  assign rx_ok   = (rx_state == S_STOP) && rx_last && rxs;
  assign rx_bad  = (rx_state == S_STOP) && rx_last && !rxs;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state <= S_IDLE;
      rx_div   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_armed <= 1'b0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          rx_div <= '0;
          // A line still low after a bad stop bit must not restart.
          if (!rx_armed) begin
            rx_armed <= rxs;
          end else if (!rxs) begin
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_div == HALF_LAST) begin
            rx_div <= '0;
            rx_bit <= '0;
            if (rxs) begin
              rx_state <= S_IDLE;
            end else begin
              rx_state <= S_DATA;
            end
          end else begin
            rx_div <= rx_div + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_last) begin
            rx_div <= '0;
            rx_sh  <= {rxs, rx_sh[7:1]};
            if (rx_bit == 3'd7) begin
              rx_state <= S_STOP;
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_div <= rx_div + 1'b1;
          end
        end
        default: begin
          if (rx_last) begin
            rx_div   <= '0;
            rx_armed <= 1'b0;
            rx_state <= S_IDLE;
          end else begin
            rx_div <= rx_div + 1'b1;
          end
        end
      endcase
    end
  end

  // Flags: a hardware set beats a same-cycle read clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rx_ok) begin
        rx_data <= rx_sh;
      end
      if (rx_ok) begin
        rx_valid <= 1'b1;
      end else if (inp_edge && sel_data) begin
        rx_valid <= 1'b0;
      end
      if (rx_ok && rx_valid) begin
        overrun <= 1'b1;
      end else if (inp_edge && sel_stat) begin
        overrun <= 1'b0;
      end
      if (rx_bad) begin
        frame_err <= 1'b1;
      end else if (inp_edge && sel_stat) begin
        frame_err <= 1'b0;
      end
    end
  end

  // ---------------- CPU read mux ----------------
  logic [7:0] status;

  assign status = {3'b000, frame_err, overrun,
                   rx_valid, tx_full, tx_empty};

  always_comb begin
    io_din = 8'h00;
    unique case (1'b1)
      io_inp && sel_data: io_din = rx_data;
      io_inp && sel_stat: io_din = status;
      default:            io_din = 8'h00;
    endcase
  end

  assign irq = rx_valid | tx_empty;

endmodule
